ring_token_arbiter: RTL and testbench
=====================================

Name: ring_token_arbiter

Overview:
Per-core arbiter that shares this core's single ring-token claim among four local ring clients: data/instruction cache, messenger, locker and barrier unit. It pre-selects one winner in round-robin order and arms that client before the token arrives. It holds ownership until the client signals release. Its per-client wait outputs replace the ad-hoc msgrWaiting/lockerWaiting/barrierWaiting gating in each client's waitToken state.

Parameters:
NREQ, 4, number of requesters (bit 0 cache, 1 messenger, 2 locker, 3 barrier); the RTL supports 2..8.
TIMEOUT_CYCLES, 1024, maximum cycles one client may own the token before a watchdog flag; 0 disables the watchdog.
TCW, 11, width of the watchdog counter; must satisfy 2^TCW > TIMEOUT_CYCLES.

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  level request; a client holds it from wanting the ring until release
rel  input  NREQ  one-cycle pulse; the owner has finished its ring transaction and forwarded the token
SlotTypeIn  input  4  ring slot type at this node (Token = 1)
arm  output  NREQ  one-hot; only the armed client may seize the next Token slot
owner  output  NREQ  one-hot; client currently holding the token
waiting  output  NREQ  req & ~arm & ~owner; a client must not seize a token while its bit is set
busy  output  1  state != IDLE
timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; arm = 0, owner = 0, timeout = 0, busy = 0; ptr = 0; wdog = 0.
- States: IDLE, ARMED, OWNED. All outputs are registered except waiting, which is combinational.
- Winner selection: the first set bit of req, scanning circularly from ptr upward (mod NREQ).
- IDLE:
  - If |req: arm <= onehot(winner), state <= ARMED.
  - Otherwise stay in IDLE.
- ARMED:
  - If SlotTypeIn == Token and req[armed] is set: the client seizes that same token. owner <= arm, arm <= 0, wdog <= 0, state <= OWNED.
  - Else if req[armed] is clear (the request was withdrawn): arm <= 0, state <= IDLE. ptr is not advanced.
  - A token that arrives while req[armed] is clear is not claimed.
- OWNED:
  - wdog increments by 1 each cycle and saturates at all-ones.
  - If TIMEOUT_CYCLES != 0 and wdog == TIMEOUT_CYCLES - 1, set timeout. timeout stays set until reset.
  - On rel[owner]: owner <= 0, ptr <= (owner index + 1) mod NREQ, state <= IDLE.
  - rel bits that do not belong to the owner are ignored in every state.
  - A new winner is chosen in the cycle after release, so there is a minimum 1-cycle IDLE gap. This prevents the same token slot from being claimed twice.
- Requests arriving while ARMED or OWNED wait; they cannot pre-empt the armed client or the owner.
- If rel[owner] and req[owner] fall together, that is normal completion. A client that raises req again after release is served after the other pending clients.
- Reset asserted mid-transaction clears everything immediately. The clients are responsible for re-requesting.
- Fairness: with all NREQ requests held, grants rotate 0, 1, 2, 3, 0, ...

Optional Feature:
Macro ARB_DCACHE_PRIORITY_EN.
- Defined: in IDLE, if req[0] (cache) is set, the cache always wins regardless of ptr, which cuts miss latency. A cache win does not advance ptr, so rotation among the other clients is preserved. The risk is that the other clients can starve under continuous misses.
- Undefined: pure round-robin as described above.

Test Plan:
- Single client: assert req[1]; Token arrives 3 cycles later. Required: arm = 0010 one cycle after req; owner = 0010 the cycle after the Token; waiting = 0 throughout. rel[1] -> owner = 0, busy = 0 on the next edge.
- All four requesting continuously, with a Token every 10 cycles and each owner releasing after 5 cycles. Required: owner sequence 0001, 0010, 0100, 1000, 0001. waiting shows the three non-armed bits.
- Withdraw while armed: req[2] is armed, then req[2] drops before any Token while req[3] is still held. Required: arm returns to 0, and the next winner is client 2's successor (client 3). ptr stays unchanged.
- Watchdog: TIMEOUT_CYCLES = 16, owner never releases. Required: timeout rises 16 cycles after owner is set and remains 1 after a later rel, until reset.
- Async reset while OWNED: drive reset low between clock edges. Required: owner, arm, busy and timeout go to 0 without waiting for a clock edge. After reset is released with req = 0001, arming resumes from ptr = 0.
- With ARB_DCACHE_PRIORITY_EN, req = 1111 held: the cache wins every arbitration. Without it, the same stimulus produces round-robin order.

Source files
------------

// File: rtl/ring_token_arbiter_if.sv
// Bundle between the ring token arbiter and its local ring clients.
// Handshake: a client holds req until it releases; arm selects the only client
// allowed to seize the next Token slot; owner marks the holder; a one-cycle rel
// from the owner ends ownership; waiting = req & ~arm & ~owner blocks seizing.
interface ring_token_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rel;
  logic [3:0]      SlotTypeIn;
  logic [NREQ-1:0] arm;
  logic [NREQ-1:0] owner;
  logic [NREQ-1:0] waiting;
  logic            busy;
  logic            timeout;
  logic [1:0]      dbg_state;

  modport master (
    output req, rel, SlotTypeIn,
    input  arm, owner, waiting, busy, timeout, dbg_state
  );

  modport slave (
    input  req, rel, SlotTypeIn,
    output arm, owner, waiting, busy, timeout, dbg_state
  );
endinterface

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter sharing one ring-token claim among NREQ local clients.
// Optional macro ARB_DCACHE_PRIORITY_EN: client 0 (cache) wins every arbitration.
module ring_token_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TCW            = 11
) (
  input logic                 clock,
  input logic                 reset,
  ring_token_arbiter_if.slave bus
);
  localparam int              IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]      SLOT_TOKEN = 4'd1;
  localparam logic [NREQ-1:0] ONE        = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    OWNED = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] arm_q, arm_n;
  logic [NREQ-1:0] owner_q, owner_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   sel, sel_n;
  logic            prio, prio_n;
  logic [TCW-1:0]  wdog, wdog_n;
  logic            timeout_q, timeout_n;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            win_prio;
  logic [IW-1:0]   scan;

  // Circular scan from ptr upward; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = 1'b0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = IW'((int'(ptr) + k) % NREQ);
      if (!win_found && bus.req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
`ifdef ARB_DCACHE_PRIORITY_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
      win_prio  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_n   = state;
    arm_n     = arm_q;
    owner_n   = owner_q;
    ptr_n     = ptr;
    sel_n     = sel;
    prio_n    = prio;
    wdog_n    = wdog;
    timeout_n = timeout_q;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          arm_n   = ONE << win_idx;
          sel_n   = win_idx;
          prio_n  = win_prio;
          state_n = ARMED;
        end
      end
      ARMED: begin
        // A token seen while the armed request is withdrawn is left on the ring.
        if (bus.req[sel]) begin
          if (bus.SlotTypeIn == SLOT_TOKEN) begin
            owner_n = arm_q;
            arm_n   = '0;
            wdog_n  = '0;
            state_n = OWNED;
          end
        end else begin
          arm_n   = '0;
          state_n = IDLE;
        end
      end
      OWNED: begin
        if (wdog != '1) wdog_n = wdog + 1'b1;
        if (TIMEOUT_CYCLES != 0 && wdog == TCW'(TIMEOUT_CYCLES - 1)) timeout_n = 1'b1;
        if (bus.rel[sel]) begin
          owner_n = '0;
          state_n = IDLE;
          // Priority wins leave the rotation point where it was.
          if (!prio) ptr_n = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      arm_q     <= '0;
      owner_q   <= '0;
      ptr       <= '0;
      sel       <= '0;
      prio      <= 1'b0;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      arm_q     <= arm_n;
      owner_q   <= owner_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      prio      <= prio_n;
      wdog      <= wdog_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.arm       = arm_q;
  assign bus.owner     = owner_q;
  assign bus.waiting   = bus.req & ~arm_q & ~owner_q;
  assign bus.busy      = (state != IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_ring_token_arbiter;
  localparam int TO = 16;

  logic clock;
  logic reset;

  ring_token_arbiter_if #(.NREQ(4)) bus ();

  ring_token_arbiter #(
    .NREQ(4),
    .TIMEOUT_CYCLES(TO),
    .TCW(11)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: client indices (-1 = none), rotation start, cycles owned.
  int m_armed, m_owner, m_next, m_held;
  bit m_prio, m_to;

  function automatic void model_reset();
    m_armed = -1;
    m_owner = -1;
    m_next  = 0;
    m_held  = 0;
    m_prio  = 1'b0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step();
    logic [3:0] r;
    logic [3:0] l;
    r = bus.req;
    l = bus.rel;
    if (m_owner >= 0) begin
      if (m_held + 1 == TO) m_to = 1'b1;
      m_held++;
      if (((l >> m_owner) & 4'd1) != 4'd0) begin
        if (!m_prio) m_next = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else if (m_armed >= 0) begin
      if (((r >> m_armed) & 4'd1) != 4'd0) begin
        if (bus.SlotTypeIn == 4'd1) begin
          m_owner = m_armed;
          m_armed = -1;
          m_held  = 0;
        end
      end else begin
        m_armed = -1;
      end
    end else if (r != 4'd0) begin
      m_prio = 1'b0;
`ifdef ARB_DCACHE_PRIORITY_EN
      if (r[0]) begin
        m_armed = 0;
        m_prio  = 1'b1;
      end
`endif
      for (int k = 0; k < 4 && m_armed < 0; k++) begin
        if (((r >> ((m_next + k) % 4)) & 4'd1) != 4'd0) m_armed = (m_next + k) % 4;
      end
    end
  endfunction

  function automatic logic [3:0] exp_arm();
    return (m_armed >= 0) ? 4'(1 << m_armed) : 4'd0;
  endfunction

  function automatic logic [3:0] exp_owner();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("model_arm", 32'(bus.arm), 32'(exp_arm()));
    chk("model_owner", 32'(bus.owner), 32'(exp_owner()));
    chk("model_waiting", 32'(bus.waiting), 32'(bus.req & ~exp_arm() & ~exp_owner()));
    chk("model_busy", 32'(bus.busy), 32'(m_armed >= 0 || m_owner >= 0));
    chk("model_timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  // Driver tasks
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] s);
    bus.req        = r;
    bus.rel        = l;
    bus.SlotTypeIn = s;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'd0, 4'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] slot;
    logic [3:0] arm;
    logic [3:0] owner;
    logic [3:0] waiting;
    logic       busy;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] own_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] prev_own;
  logic [3:0] r_tmp;

  initial begin
    #200000;
    $display("FAIL bench_time_limit: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    drive(4'd0, 4'd0, 4'd0);
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_arm", 32'(bus.arm), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single client, token 3 cycles after arming, then release and withdraw.
    vecs[0] = '{4'b0010, 4'b0000, 4'd0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[1] = '{4'b0010, 4'b0000, 4'd0, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[2] = '{4'b0010, 4'b0000, 4'd2, 4'b0010, 4'b0000, 4'b0000, 1'b1};
    vecs[3] = '{4'b0010, 4'b0000, 4'd1, 4'b0000, 4'b0010, 4'b0000, 1'b1};
    vecs[4] = '{4'b0010, 4'b1101, 4'd1, 4'b0000, 4'b0010, 4'b0000, 1'b1};
    vecs[5] = '{4'b0000, 4'b0010, 4'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
`ifdef ARB_DCACHE_PRIORITY_EN
    vecs[6] = '{4'b1111, 4'b0000, 4'd0, 4'b0001, 4'b0000, 4'b1110, 1'b1};
`else
    vecs[6] = '{4'b1111, 4'b0000, 4'd0, 4'b0100, 4'b0000, 4'b1011, 1'b1};
`endif
    vecs[7] = '{4'b0000, 4'b0000, 4'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].req, vecs[i].rel, vecs[i].slot);
      tick();
      chk($sformatf("vec%0d_arm", i), 32'(bus.arm), 32'(vecs[i].arm));
      chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(vecs[i].owner));
      chk($sformatf("vec%0d_waiting", i), 32'(bus.waiting), 32'(vecs[i].waiting));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
    end

    // Withdraw while armed: client 2 armed, drops; client 3 is next.
    drive(4'b1100, 4'd0, 4'd0);
    tick();
    chk("wd_arm2", 32'(bus.arm), 32'b0100);
    drive(4'b1000, 4'd0, 4'd0);
    tick();
    chk("wd_arm_clear", 32'(bus.arm), 32'd0);
    chk("wd_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("wd_arm3", 32'(bus.arm), 32'b1000);

    // Watchdog: owner never releases.
    drive(4'b1000, 4'd0, 4'd1);
    tick();
    chk("wdog_owner", 32'(bus.owner), 32'b1000);
    drive(4'b1000, 4'd0, 4'd0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO - 1) chk("wdog_early", 32'(bus.timeout), 32'd0);
      if (i == TO) chk("wdog_fire", 32'(bus.timeout), 32'd1);
    end
    drive(4'b0000, 4'b1000, 4'd0);
    tick();
    chk("wdog_rel_owner", 32'(bus.owner), 32'd0);
    drive(4'b0000, 4'd0, 4'd0);
    repeat (2) tick();
    chk("wdog_sticky", 32'(bus.timeout), 32'd1);

    // Move ptr away from 0, then own client 2 and reset asynchronously.
    drive(4'b0010, 4'd0, 4'd0); tick();
    drive(4'b0010, 4'd0, 4'd1); tick();
    drive(4'b0000, 4'b0010, 4'd0); tick();
    drive(4'b0100, 4'd0, 4'd0); tick();
    drive(4'b0100, 4'd0, 4'd1); tick();
    chk("ar_owned", 32'(bus.owner), 32'b0100);
    #3 reset = 1'b0;
    #1;
    chk("ar_owner", 32'(bus.owner), 32'd0);
    chk("ar_arm", 32'(bus.arm), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_timeout", 32'(bus.timeout), 32'd0);
    model_reset();
    drive(4'b0110, 4'd0, 4'd0);
    #2 reset = 1'b1;
    tick();
    chk("ar_ptr_zero", 32'(bus.arm), 32'b0010);
    do_reset();
    drive(4'b0001, 4'd0, 4'd0);
    tick();
    chk("ar_arm0", 32'(bus.arm), 32'b0001);

    // Fairness: all requesting, token every 10 cycles, release after 5.
    do_reset();
    prev_own = 4'd0;
    for (int c = 0; c < 60; c++) begin
      drive(4'b1111,
            (m_owner >= 0 && m_held == 5) ? 4'(1 << m_owner) : 4'd0,
            (c % 10 == 9) ? 4'd1 : 4'd0);
      tick();
      if (bus.owner != 4'd0 && prev_own == 4'd0) own_q.push_back(bus.owner);
      prev_own = bus.owner;
    end
`ifdef ARB_DCACHE_PRIORITY_EN
    exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    chk("fair_grants", 32'(own_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < own_q.size(); i++)
      chk($sformatf("fair_owner%0d", i), 32'(own_q[i]), 32'(exp_q[i]));

    // Randomized traffic against the model.
    do_reset();
    r_tmp = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) r_tmp[$urandom_range(0, 3)] ^= 1'b1;
      drive(r_tmp,
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
            ($urandom_range(0, 3) == 0) ? 4'd1 : 4'($urandom_range(0, 15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
